// File: rtl/sw_led_group_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sw_led_pkg
//  Description : Shared types and default parameter values for the
//                switch/LED group controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package sw_led_pkg;

    // Blanking behaviour selected by the mode input
    typedef enum logic {
        MODE_MOMENTARY = 1'b0,
        MODE_TOGGLE    = 1'b1
    } mode_e;

    localparam int c_DEF_N_GROUPS        = 4;
    localparam int c_DEF_GROUP_W         = 4;
    localparam int c_DEF_DEBOUNCE_CYCLES = 500000;

endpackage : sw_led_pkg
`default_nettype wire

// File: rtl/sw_led_group_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : One push button: 2-flop synchroniser, stability counter,
//                debounced level and a one-cycle pulse on each accepted press.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import sw_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_db,
    output logic o_press
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_db;
    logic               r_db_q;
    logic [c_CNT_W-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
        end
    end

    // Accept a new level only after it differs from db for DEBOUNCE_CYCLES
    // consecutive cycles; any return to equality restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db   <= 1'b0;
            r_db_q <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_db_q <= r_db;
            if (r_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_db  <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_db    = r_db;
    // Rising edge of the debounced level only; releases give no pulse
    assign o_press = r_db & ~r_db_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/sw_led_group_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sw_led_group_ctrl
//  Description : Drives N_GROUPS groups of LEDs from synchronised switches,
//                each group blankable by its own debounced button, either
//                while held (momentary) or per press (toggle).
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_led_group_ctrl
    import sw_led_pkg::*;
#(
    parameter int N_GROUPS        = c_DEF_N_GROUPS,
    parameter int GROUP_W         = c_DEF_GROUP_W,
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_GROUPS*GROUP_W-1:0]   sw,
    input  logic [N_GROUPS-1:0]           btn,
    input  logic                          mode,
    output logic [N_GROUPS*GROUP_W-1:0]   led,
    output logic [N_GROUPS-1:0]           blank
);

    localparam int c_LED_W = N_GROUPS * GROUP_W;

    // Refuse to build with parameters the counter or bit mapping cannot handle
    if (DEBOUNCE_CYCLES < 2 || N_GROUPS < 1 || GROUP_W < 1) begin : g_param_check
        $fatal(1, "sw_led_group_ctrl: illegal parameter value");
    end

    logic [c_LED_W-1:0]  r_sw_meta;
    logic [c_LED_W-1:0]  r_sw_sync;
    logic [N_GROUPS-1:0] w_db;
    logic [N_GROUPS-1:0] w_press;
    logic [N_GROUPS-1:0] r_blank;
    logic [c_LED_W-1:0]  w_led_nxt;
    logic [c_LED_W-1:0]  r_led;

    // One independent debouncer and LED mask per group
    for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (btn[g]),
            .o_db    (w_db[g]),
            .o_press (w_press[g])
        );

        assign w_led_nxt[g*GROUP_W +: GROUP_W] =
            r_sw_sync[g*GROUP_W +: GROUP_W] & {GROUP_W{~r_blank[g]}};
    end

    // Bring the asynchronous switches into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Blanking follows the held button or flips per press; a mode change
    // keeps the current blank value as the starting point
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blank <= '0;
        end else if (mode_e'(mode) == MODE_TOGGLE) begin
            r_blank <= r_blank ^ w_press;
        end else begin
            r_blank <= w_db;
        end
    end

    // Register the masked switch image onto the LEDs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    assign led   = r_led;
    assign blank = r_blank;

endmodule : sw_led_group_ctrl
`default_nettype wire

// File: doc/sw_led_group_ctrl.md
SW_LED_GROUP_CTRL -- requirements
Module: sw_led_group_ctrl

Interface
REQ-001 Parameter N_GROUPS, default 4: number of switch/LED groups, each with one button.
REQ-002 Parameter GROUP_W, default 4: switches/LEDs per group.
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000: cycles a synchronised button level must be stable to be accepted; legal range ≥ 2.
REQ-004 Port clk  input  1: single clock; all state on rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port sw  input  N_GROUPS*GROUP_W: asynchronous switches; group g = sw[g*GROUP_W +: GROUP_W].
REQ-007 Port btn  input  N_GROUPS: asynchronous, bouncing push buttons, 1 = pressed; btn[g] controls group g.
REQ-008 Port mode  input  1: 0 = MOMENTARY (group blanked while button held), 1 = TOGGLE (each press flips group blanking).
REQ-009 Port led  output  N_GROUPS*GROUP_W: registered LED drive, same bit mapping as sw.
REQ-010 Port blank  output  N_GROUPS: registered per-group blanking state, 1 = group forced off.

Function
REQ-011 sw and btn SHALL each pass through a 2-flop synchroniser; synchronised value visible 2 cycles after input edge.
REQ-012 Per button: debounced level db[g] and counter cnt[g] (width $clog2(DEBOUNCE_CYCLES)); sync value == db: cnt <= 0.
REQ-013 Sync value != db: cnt increments; at cnt == DEBOUNCE_CYCLES-1 with mismatch still present, db <= sync value and cnt <= 0.
REQ-014 A mismatch lasting fewer than DEBOUNCE_CYCLES consecutive cycles SHALL NOT change db (glitch rejection; any return to equality restarts count).
REQ-015 press[g] SHALL be a one-cycle pulse in the cycle db[g] rises (db & ~db_q); releases generate no pulse.
REQ-016 blank[g] register: mode=0 -> blank <= db; mode=1 -> blank <= blank ^ press.
REQ-017 Mode change SHALL take effect next cycle with no reset of state; TOGGLE starts from current blank value.
REQ-018 led register: led <= sw_sync AND NOT blank expanded per group (each group's GROUP_W bits masked by its blank bit).
REQ-019 Latency: sw edge to led = 3 cycles; stable btn edge at cycle t -> db at t+2+DEBOUNCE_CYCLES, blank at t+3+DEBOUNCE_CYCLES, led at t+4+DEBOUNCE_CYCLES.
REQ-020 Groups SHALL be fully independent; simultaneous presses on several groups each take effect in the same cycle.
REQ-021 Button held indefinitely in TOGGLE mode SHALL toggle exactly once.

Reset
REQ-022 rst=1 at a clock edge SHALL clear synchronisers, db, db_q, cnt, blank and led to 0.
REQ-023 Reset mid-debounce SHALL discard the partial count; a button held through reset re-qualifies after DEBOUNCE_CYCLES+2 cycles and, in TOGGLE mode, produces one press.
REQ-024 First led update after rst deasserts SHALL reflect sw sampled post-reset (no stale data).

Structure
REQ-025 Package sw_led_pkg SHALL hold the mode enum (MODE_MOMENTARY=0, MODE_TOGGLE=1) and default parameter constants.
REQ-026 Sub-module btn_debounce (synchroniser, counter, db, press pulse) SHALL be instantiated N_GROUPS times via generate.
REQ-027 Elaboration SHALL fail if DEBOUNCE_CYCLES < 2, N_GROUPS < 1 or GROUP_W < 1.

Verification (N_GROUPS=4, GROUP_W=4, DEBOUNCE_CYCLES=4)
REQ-028 Reset: rst 2 cycles, sw=16'hFFFF, btn=0 -> led=0 and blank=0 during reset; led=16'hFFFF exactly 3 cycles after rst deasserts.
REQ-029 Glitch: mode=0, btn[1] high 3 cycles then low -> blank stays 4'b0000, led unchanged.
REQ-030 Momentary: mode=0, btn[2] high at t, held -> blank=4'b0100 at t+7, led=16'hF0FF at t+8; release -> restored DEBOUNCE_CYCLES+4 cycles later.
REQ-031 Toggle: mode=1, two clean presses on btn[0] separated by 20 cycles -> blank[0] 1 after first, 0 after second; held button toggles once.
REQ-032 Simultaneous: mode=1, btn=4'b1010 same cycle -> blank=4'b1010 same cycle, led=16'h0F0F with sw=16'hFFFF.
REQ-033 Reset mid-debounce: btn[3] high, rst at 2 cycles into count -> blank=0, then blank[3]=1 at DEBOUNCE_CYCLES+3 cycles after rst release (mode=1).
